// File: rtl/vote_input_conditioner.sv
// Voting-panel front end: synchronizes and debounces the candidate switches and mode buttons,
// then turns each press-from-all-released into a single validated ballot or an error pulse.
module vote_input_conditioner #(
    parameter int unsigned DB_CYCLES = 1000
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic [3:0] i_v_raw,
    input  logic       i_enable_raw,
    input  logic       i_next_raw,
    output logic [3:0] o_v_clean,
    output logic       o_vote_valid,
    output logic [1:0] o_vote_id,
    output logic       o_vote_err,
    output logic [7:0] o_err_count,
    output logic       o_enable_pulse,
    output logic       o_next_pulse
);

    localparam int unsigned CntW = 16;
    localparam logic [CntW-1:0] DbLast = CntW'(DB_CYCLES - 1);
    localparam logic [CntW-1:0] DbFull = CntW'(DB_CYCLES);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    typedef enum logic {
        StLocked = 1'b0,
        StIdle   = 1'b1
    } state_t;

    // Synchronizer stages
    logic [3:0] r_v_s1, r_v_s2;
    logic       r_en_s1, r_en_s2;
    logic       r_nx_s1, r_nx_s2;

    // Debounce state: previous sync2 sample, accepted value, run counter
    logic [3:0]      r_v_prev, r_v_stable;
    logic [CntW-1:0] r_v_cnt;
    logic            r_en_prev, r_en_stable;
    logic [CntW-1:0] r_en_cnt;
    logic            r_nx_prev, r_nx_stable;
    logic [CntW-1:0] r_nx_cnt;

    logic [3:0]      w_v_stable_d;
    logic [CntW-1:0] w_v_cnt_d, w_v_cnt_inc;
    logic            w_en_stable_d;
    logic [CntW-1:0] w_en_cnt_d, w_en_cnt_inc;
    logic            w_nx_stable_d;
    logic [CntW-1:0] w_nx_cnt_d, w_nx_cnt_inc;

    // Edge detection and ballot state
    logic [3:0]      r_v_clean_d1;
    logic            r_en_stable_d1, r_nx_stable_d1;
    logic            r_enable_pulse, r_next_pulse;
    logic [CntW-1:0] r_zrun;
    logic [CntW-1:0] w_zrun_d;
    state_t          r_state, w_state_d;
    logic            r_vote_valid, r_vote_err;
    logic [1:0]      r_vote_id;
    logic [7:0]      r_err_count;

    logic            w_vote_valid_d, w_vote_err_d;
    logic [1:0]      w_vote_id_d;
    logic [7:0]      w_err_count_d;
    logic            w_rise, w_onehot;
    logic [1:0]      w_enc;

    // Switch vector debounced as one word so any bit change restarts the whole count
    always_comb begin
        w_v_cnt_inc  = r_v_cnt + CntOne;
        w_v_cnt_d    = '0;
        w_v_stable_d = r_v_stable;
        if ((r_v_s2 != r_v_prev) || (r_v_s2 == r_v_stable)) begin
            w_v_cnt_d = '0;
        end else if (w_v_cnt_inc == DbLast) begin
            w_v_stable_d = r_v_s2;
            w_v_cnt_d    = '0;
        end else begin
            w_v_cnt_d = w_v_cnt_inc;
        end
    end

    always_comb begin
        w_en_cnt_inc  = r_en_cnt + CntOne;
        w_en_cnt_d    = '0;
        w_en_stable_d = r_en_stable;
        if ((r_en_s2 != r_en_prev) || (r_en_s2 == r_en_stable)) begin
            w_en_cnt_d = '0;
        end else if (w_en_cnt_inc == DbLast) begin
            w_en_stable_d = r_en_s2;
            w_en_cnt_d    = '0;
        end else begin
            w_en_cnt_d = w_en_cnt_inc;
        end
    end

    always_comb begin
        w_nx_cnt_inc  = r_nx_cnt + CntOne;
        w_nx_cnt_d    = '0;
        w_nx_stable_d = r_nx_stable;
        if ((r_nx_s2 != r_nx_prev) || (r_nx_s2 == r_nx_stable)) begin
            w_nx_cnt_d = '0;
        end else if (w_nx_cnt_inc == DbLast) begin
            w_nx_stable_d = r_nx_s2;
            w_nx_cnt_d    = '0;
        end else begin
            w_nx_cnt_d = w_nx_cnt_inc;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_v_s1      <= '0;
            r_v_s2      <= '0;
            r_en_s1     <= 1'b0;
            r_en_s2     <= 1'b0;
            r_nx_s1     <= 1'b0;
            r_nx_s2     <= 1'b0;
            r_v_prev    <= '0;
            r_v_stable  <= '0;
            r_v_cnt     <= '0;
            r_en_prev   <= 1'b0;
            r_en_stable <= 1'b0;
            r_en_cnt    <= '0;
            r_nx_prev   <= 1'b0;
            r_nx_stable <= 1'b0;
            r_nx_cnt    <= '0;
        end else begin
            r_v_s1      <= i_v_raw;
            r_v_s2      <= r_v_s1;
            r_en_s1     <= i_enable_raw;
            r_en_s2     <= r_en_s1;
            r_nx_s1     <= i_next_raw;
            r_nx_s2     <= r_nx_s1;
            r_v_prev    <= r_v_s2;
            r_v_stable  <= w_v_stable_d;
            r_v_cnt     <= w_v_cnt_d;
            r_en_prev   <= r_en_s2;
            r_en_stable <= w_en_stable_d;
            r_en_cnt    <= w_en_cnt_d;
            r_nx_prev   <= r_nx_s2;
            r_nx_stable <= w_nx_stable_d;
            r_nx_cnt    <= w_nx_cnt_d;
        end
    end

    // Re-arming looks at sync2 directly, not v_clean, so it needs its own zero-run counter
    always_comb begin
        if (r_v_s2 != 4'b0000) begin
            w_zrun_d = '0;
        end else if (r_zrun != DbFull) begin
            w_zrun_d = r_zrun + CntOne;
        end else begin
            w_zrun_d = r_zrun;
        end
    end

    assign w_rise   = (r_v_clean_d1 == 4'b0000) && (r_v_stable != 4'b0000);
    assign w_onehot = (r_v_stable != 4'b0000) && ((r_v_stable & (r_v_stable - 4'd1)) == 4'b0000);
    assign w_enc    = {r_v_stable[3] | r_v_stable[2], r_v_stable[3] | r_v_stable[1]};

    always_comb begin
        w_state_d      = r_state;
        w_vote_valid_d = 1'b0;
        w_vote_err_d   = 1'b0;
        w_vote_id_d    = r_vote_id;
        w_err_count_d  = r_err_count;
        unique case (r_state)
            StIdle: begin
                if (w_rise) begin
                    w_state_d = StLocked;
                    if (w_onehot) begin
                        w_vote_valid_d = 1'b1;
                        w_vote_id_d    = w_enc;
                    end else begin
                        w_vote_err_d = 1'b1;
                        if (r_err_count != 8'hFF) begin
                            w_err_count_d = r_err_count + 8'd1;
                        end
                    end
                end
            end
            StLocked: begin
                if (r_zrun == DbFull) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StLocked;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state        <= StLocked;
            r_zrun         <= '0;
            r_v_clean_d1   <= '0;
            r_en_stable_d1 <= 1'b0;
            r_nx_stable_d1 <= 1'b0;
            r_enable_pulse <= 1'b0;
            r_next_pulse   <= 1'b0;
            r_vote_valid   <= 1'b0;
            r_vote_err     <= 1'b0;
            r_vote_id      <= '0;
            r_err_count    <= '0;
        end else begin
            r_state        <= w_state_d;
            r_zrun         <= w_zrun_d;
            r_v_clean_d1   <= r_v_stable;
            r_en_stable_d1 <= r_en_stable;
            r_nx_stable_d1 <= r_nx_stable;
            r_enable_pulse <= r_en_stable & ~r_en_stable_d1;
            r_next_pulse   <= r_nx_stable & ~r_nx_stable_d1;
            r_vote_valid   <= w_vote_valid_d;
            r_vote_err     <= w_vote_err_d;
            r_vote_id      <= w_vote_id_d;
            r_err_count    <= w_err_count_d;
        end
    end

    assign o_v_clean      = r_v_stable;
    assign o_vote_valid   = r_vote_valid;
    assign o_vote_id      = r_vote_id;
    assign o_vote_err     = r_vote_err;
    assign o_err_count    = r_err_count;
    assign o_enable_pulse = r_enable_pulse;
    assign o_next_pulse   = r_next_pulse;

endmodule

// File: tb/tb_vote_input_conditioner.sv
// Scoreboard bench: a window-based reference model predicts every output pulse and its edge;
// a negedge monitor pops and compares whenever the DUT pulses.
module tb_vote_input_conditioner;

    localparam int unsigned DB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] v_raw = 4'b0000;
    logic       en_raw = 1'b0;
    logic       nx_raw = 1'b0;

    logic [3:0] o_v_clean;
    logic       o_vote_valid, o_vote_err, o_enable_pulse, o_next_pulse;
    logic [1:0] o_vote_id;
    logic [7:0] o_err_count;

    vote_input_conditioner #(.DB_CYCLES(DB)) dut (
        .i_clock        (clk),
        .i_reset_n      (rst_n),
        .i_v_raw        (v_raw),
        .i_enable_raw   (en_raw),
        .i_next_raw     (nx_raw),
        .o_v_clean      (o_v_clean),
        .o_vote_valid   (o_vote_valid),
        .o_vote_id      (o_vote_id),
        .o_vote_err     (o_vote_err),
        .o_err_count    (o_err_count),
        .o_enable_pulse (o_enable_pulse),
        .o_next_pulse   (o_next_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0 vote_valid, 1 vote_err, 2 enable_pulse, 3 next_pulse
        int due;
        int id;
        int errc;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;

    // Reference model: inputs reach sync2 two samples late; a value is accepted once the last
    // DB sync2 samples all agree on it; the panel arms after DB all-zero samples.
    logic [5:0] m_d1, m_d2;
    logic [5:0] win[$];
    logic [3:0] m_clean;
    logic       m_en, m_nx, m_armed;
    int         m_errc, m_id;

    initial begin
        m_d1 = '0; m_d2 = '0; m_clean = '0; m_en = 0; m_nx = 0; m_armed = 0;
        m_errc = 0; m_id = 0;
    end

    always @(posedge clk) begin
        logic [5:0] s;
        logic [3:0] nv;
        logic       ne, nn, vs, es, ns, full;
        ev_t        ev;
        cyc++;
        if (!rst_n) begin
            m_d1 = '0; m_d2 = '0; win.delete(); m_clean = '0; m_en = 0; m_nx = 0;
            m_armed = 0; m_errc = 0; m_id = 0; q.delete();
        end else begin
            s = m_d2; m_d2 = m_d1; m_d1 = {nx_raw, en_raw, v_raw};
            win.push_back(s);
            if (win.size() > DB) void'(win.pop_front());
            full = (win.size() == DB);
            vs = 1; es = 1; ns = 1;
            for (int i = 1; i < win.size(); i++) begin
                if (win[i][3:0] != win[0][3:0]) vs = 0;
                if (win[i][4] != win[0][4]) es = 0;
                if (win[i][5] != win[0][5]) ns = 0;
            end
            nv = (full && vs) ? win[0][3:0] : m_clean;
            ne = (full && es) ? win[0][4] : m_en;
            nn = (full && ns) ? win[0][5] : m_nx;
            if (m_armed && m_clean == 4'b0000 && nv != 4'b0000) begin
                m_armed = 0;
                if ($countones(nv) == 1) begin
                    for (int b = 0; b < 4; b++) if (nv[b]) m_id = b;
                    ev.kind = 0;
                end else begin
                    if (m_errc < 255) m_errc++;
                    ev.kind = 1;
                end
                ev.due = cyc + 1; ev.id = m_id; ev.errc = m_errc;
                q.push_back(ev);
            end
            if (full && vs && win[0][3:0] == 4'b0000) m_armed = 1;
            if (!m_en && ne) begin
                ev.kind = 2; ev.due = cyc + 1; ev.id = 0; ev.errc = 0; q.push_back(ev);
            end
            if (!m_nx && nn) begin
                ev.kind = 3; ev.due = cyc + 1; ev.id = 0; ev.errc = 0; q.push_back(ev);
            end
            m_clean = nv; m_en = ne; m_nx = nn;
        end
    end

    // Monitor
    always @(negedge clk) begin
        logic [3:0] pulses;
        ev_t        e;
        pulses = {o_next_pulse, o_enable_pulse, o_vote_err, o_vote_valid};
        checks++;
        if (o_v_clean !== m_clean) begin
            failures++;
            $display("FAIL v_clean cyc=%0d got=%b exp=%b", cyc, o_v_clean, m_clean);
        end
        checks++;
        if (o_vote_valid === 1'b1 && o_vote_err === 1'b1) begin
            failures++;
            $display("FAIL valid_err_exclusive cyc=%0d got both asserted exp one", cyc);
        end
        for (int k = 0; k < 4; k++) begin
            if (pulses[k] === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse cyc=%0d got kind=%0d exp none", cyc, k);
                end else begin
                    e = q.pop_front();
                    if (e.kind != k || e.due != cyc ||
                        (k < 2 && (int'(o_vote_id) != e.id || int'(o_err_count) != e.errc))) begin
                        failures++;
                        $display("FAIL pulse cyc=%0d got kind=%0d id=%0d errc=%0d exp kind=%0d due=%0d id=%0d errc=%0d",
                                 cyc, k, o_vote_id, o_err_count, e.kind, e.due, e.id, e.errc);
                    end
                end
            end
        end
        while (q.size() > 0 && q[0].due < cyc) begin
            e = q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_pulse cyc=%0d got none exp kind=%0d due=%0d", cyc, e.kind, e.due);
        end
    end

    task automatic drive(input logic [3:0] v, input logic e, input logic n, input int cycles);
        v_raw = v; en_raw = e; nx_raw = n;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic wait_for_valid(output int waited);
        waited = 0;
        while (o_vote_valid !== 1'b1 && waited < 30) begin
            @(negedge clk);
            waited++;
        end
    endtask

    initial begin
        int c0, n;
        logic [3:0] rv;
        @(negedge clk);
        do_reset(3);
        check("reset_outputs",
              int'({o_v_clean, o_vote_valid, o_vote_id, o_vote_err, o_err_count,
                    o_enable_pulse, o_next_pulse}), 0);

        // First vote and its latency
        drive(4'b0000, 0, 0, 6);
        c0 = cyc;
        v_raw = 4'b0100;
        wait_for_valid(n);
        check("first_vote_seen", int'(o_vote_valid === 1'b1), 1);
        check("first_vote_latency", cyc - c0, 7);
        check("first_vote_id", int'(o_vote_id), 2);
        check("first_vote_errc", int'(o_err_count), 0);
        drive(4'b0100, 0, 0, 6);
        drive(4'b0000, 0, 0, 10);

        // Short glitch must not reach v_clean
        drive(4'b0010, 0, 0, 3);
        drive(4'b0000, 0, 0, 10);
        check("glitch_no_vote_errc", int'(o_err_count), 0);

        // Invalid ballot then change without release
        drive(4'b0110, 0, 0, 12);
        check("bad_ballot_errc", int'(o_err_count), 1);
        check("bad_ballot_id_kept", int'(o_vote_id), 2);
        drive(4'b0010, 0, 0, 12);
        check("locked_id_kept", int'(o_vote_id), 2);
        drive(4'b0000, 0, 0, 10);

        // Two votes with release, then a second vote without release
        drive(4'b0001, 0, 0, 10);
        check("vote_a_id", int'(o_vote_id), 0);
        drive(4'b0000, 0, 0, 10);
        drive(4'b1000, 0, 0, 10);
        check("vote_b_id", int'(o_vote_id), 3);
        drive(4'b0000, 0, 0, 10);
        drive(4'b0001, 0, 0, 10);
        drive(4'b1000, 0, 0, 10);
        check("no_release_id", int'(o_vote_id), 0);
        drive(4'b0000, 0, 0, 10);

        // Switch held through reset must not vote
        drive(4'b0001, 0, 0, 10);
        do_reset(2);
        drive(4'b0001, 0, 0, 12);
        check("held_through_reset_clean", int'(o_v_clean), 1);
        drive(4'b0000, 0, 0, 10);
        c0 = cyc;
        v_raw = 4'b0001;
        wait_for_valid(n);
        check("fresh_press_latency", cyc - c0, 7);
        drive(4'b0001, 0, 0, 6);
        drive(4'b0000, 0, 0, 10);

        // Both buttons together
        en_raw = 1; nx_raw = 1;
        n = 0;
        while (o_enable_pulse !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("buttons_same_edge", int'({o_enable_pulse, o_next_pulse}), 3);
        drive(4'b0000, 1, 1, 6);
        drive(4'b0000, 0, 0, 10);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 200; i++) begin
            rv = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) begin
                do_reset($urandom_range(1, 2));
            end
            drive(rv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(1, 9));
        end
        drive(4'b0000, 0, 0, 12);

        // Error counter saturation
        do_reset(2);
        drive(4'b0000, 0, 0, 8);
        for (int i = 0; i < 300; i++) begin
            drive(4'b0011, 0, 0, 7);
            drive(4'b0000, 0, 0, 7);
        end
        check("err_count_saturated", int'(o_err_count), 255);
        drive(4'b0000, 0, 0, 5);
        check("scoreboard_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
